// File: rtl/ow_pkg.sv
// Shared 1-Wire engine op codes, DS18B20 commands and scheduler state encoding.
package ow_pkg;

   localparam logic [1:0] OP_RESET = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;

   localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
   localparam logic [7:0] CMD_CONVERT  = 8'h44;
   localparam logic [7:0] CMD_READ_SP  = 8'hBE;

   localparam int unsigned SP_LEN  = 9;
   localparam int unsigned CNT_W   = 20;
   localparam int unsigned RETRY_W = 4;
   localparam int unsigned IDX_W   = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RST1,
      S_SKIP1,
      S_CONV,
      S_WAIT,
      S_RST2,
      S_SKIP2,
      S_RDCMD,
      S_RDBYTE,
      S_CHECK,
      S_DONE,
      S_FAIL_P,
      S_FAIL_C
   } state_e;

endpackage

// File: rtl/ds18b20_sched_if.sv
// Request/done handshake between the conversion scheduler and the byte-level 1-Wire engine.
interface ds18b20_sched_if;

   logic       ow_req;
   logic [1:0] ow_op;
   logic [7:0] ow_wdata;
   logic       ow_done;
   logic [7:0] ow_rdata;
   logic       ow_presence;

   modport master (
      output ow_req, ow_op, ow_wdata,
      input  ow_done, ow_rdata, ow_presence
   );

   modport slave (
      input  ow_req, ow_op, ow_wdata,
      output ow_done, ow_rdata, ow_presence
   );

endinterface

// File: rtl/crc8_maxim.sv
// One-byte update of the Dallas/Maxim CRC-8 (reflected poly 0x8C), data consumed LSB-first.
module crc8_maxim (
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   always_comb begin
      logic [7:0] c;
      c = crc_in ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ({1'b0, c[7:1]} ^ 8'h8C) : {1'b0, c[7:1]};
      end
      crc_out = c;
   end

endmodule

// File: rtl/ds18b20_sched.sv
// DS18B20 conversion scheduler: drives reset/skip/convert/wait/read steps through a 1-Wire
// byte engine, validates the scratchpad CRC and publishes the raw temperature.
module ds18b20_sched
   import ow_pkg::*;
#(
   parameter int unsigned CONV_WAIT_CYC = 768000,
   parameter int unsigned PERIOD_CYC    = 1024000,
   parameter int unsigned MAX_RETRY     = 3
) (
   input  logic                   clk_in,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   auto_en,
   ds18b20_sched_if.master        ow,
   output logic                   busy,
   output logic [15:0]            temp_raw,
   output logic                   temp_valid,
   output logic                   err_presence,
   output logic                   err_crc
);

   localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(CONV_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0]   PER_LAST  = CNT_W'(PERIOD_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(SP_LEN - 1);

   state_e             state_q, state_d;
   logic               req_q, req_d;
   logic [1:0]         op_q, op_d, op_sel;
   logic [7:0]         wdata_q, wdata_d, wdata_sel;
   logic [CNT_W-1:0]   wait_q, wait_d, per_q, per_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [7:0]         crc_q, crc_d, crc_nx;
   logic               nz_q, nz_d;
   logic [7:0]         b0_q, b0_d, b1_q, b1_d;
   logic [15:0]        temp_d;
   logic               tv_d, ep_d, ec_d, busy_d;
   logic               is_op, step_done, per_exp;

   assign ow.ow_req   = req_q;
   assign ow.ow_op    = op_q;
   assign ow.ow_wdata = wdata_q;

   crc8_maxim u_crc (
      .crc_in  (crc_q),
      .data    (ow.ow_rdata),
      .crc_out (crc_nx)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         req_q        <= 1'b0;
         op_q         <= OP_RESET;
         wdata_q      <= '0;
         wait_q       <= '0;
         per_q        <= '0;
         retry_q      <= '0;
         idx_q        <= '0;
         crc_q        <= '0;
         nz_q         <= 1'b0;
         b0_q         <= '0;
         b1_q         <= '0;
         busy         <= 1'b0;
         temp_raw     <= '0;
         temp_valid   <= 1'b0;
         err_presence <= 1'b0;
         err_crc      <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         op_q         <= op_d;
         wdata_q      <= wdata_d;
         wait_q       <= wait_d;
         per_q        <= per_d;
         retry_q      <= retry_d;
         idx_q        <= idx_d;
         crc_q        <= crc_d;
         nz_q         <= nz_d;
         b0_q         <= b0_d;
         b1_q         <= b1_d;
         busy         <= busy_d;
         temp_raw     <= temp_d;
         temp_valid   <= tv_d;
         err_presence <= ep_d;
         err_crc      <= ec_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      op_d      = op_q;
      wdata_d   = wdata_q;
      wait_d    = wait_q;
      retry_d   = retry_q;
      idx_d     = idx_q;
      crc_d     = crc_q;
      nz_d      = nz_q;
      b0_d      = b0_q;
      b1_d      = b1_q;
      temp_d    = temp_raw;
      tv_d      = 1'b0;
      ep_d      = err_presence;
      ec_d      = err_crc;
      is_op     = 1'b0;
      op_sel    = OP_RESET;
      wdata_sel = 8'h00;
      step_done = req_q & ow.ow_done;
      per_exp   = (per_q == PER_LAST);

      // Held at expiry while disabled so enabling auto mode fires a sequence at once.
      if (!auto_en)      per_d = PER_LAST;
      else if (!per_exp) per_d = per_q + CNT_W'(1);
      else               per_d = per_q;

      case (state_q)
         S_IDLE: begin
            if (start || (auto_en && per_exp)) begin
               state_d = S_RST1;
               retry_d = '0;
               per_d   = '0;
            end
         end
         S_RST1, S_RST2: begin
            is_op  = 1'b1;
            op_sel = OP_RESET;
            if (step_done) begin
               if (!ow.ow_presence)       state_d = S_FAIL_P;
               else if (state_q == S_RST1) state_d = S_SKIP1;
               else                        state_d = S_SKIP2;
            end
         end
         S_SKIP1, S_SKIP2: begin
            is_op     = 1'b1;
            op_sel    = OP_WRITE;
            wdata_sel = CMD_SKIP_ROM;
            if (step_done) state_d = (state_q == S_SKIP1) ? S_CONV : S_RDCMD;
         end
         S_CONV: begin
            is_op     = 1'b1;
            op_sel    = OP_WRITE;
            wdata_sel = CMD_CONVERT;
            if (step_done) begin
               state_d = S_WAIT;
               wait_d  = '0;
            end
         end
         S_WAIT: begin
            if (wait_q == WAIT_LAST) state_d = S_RST2;
            else                     wait_d  = wait_q + CNT_W'(1);
         end
         S_RDCMD: begin
            is_op     = 1'b1;
            op_sel    = OP_WRITE;
            wdata_sel = CMD_READ_SP;
            if (step_done) begin
               state_d = S_RDBYTE;
               idx_d   = '0;
               crc_d   = '0;
               nz_d    = 1'b0;
            end
         end
         S_RDBYTE: begin
            is_op  = 1'b1;
            op_sel = OP_READ;
            if (step_done) begin
               if (idx_q == IDX_W'(0)) b0_d = ow.ow_rdata;
               if (idx_q == IDX_W'(1)) b1_d = ow.ow_rdata;
               crc_d = crc_nx;
               nz_d  = nz_q | (|ow.ow_rdata);
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) state_d = S_CHECK;
            end
         end
         // A stuck-low bus reads all zeros, which also has a zero CRC residue.
         S_CHECK: state_d = (crc_q == 8'h00 && nz_q) ? S_DONE : S_FAIL_C;
         S_DONE: begin
            temp_d  = {b1_q, b0_q};
            tv_d    = 1'b1;
            ep_d    = 1'b0;
            ec_d    = 1'b0;
            state_d = S_IDLE;
         end
         S_FAIL_P: begin
            retry_d = retry_q + RETRY_W'(1);
            if (retry_d < RETRY_MAX) state_d = S_RST1;
            else begin
               ep_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_FAIL_C: begin
            retry_d = retry_q + RETRY_W'(1);
            if (retry_d < RETRY_MAX) state_d = S_RST1;
            else begin
               ec_d    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Raise on entry to an op step; drop after done, leaving one idle cycle before the next.
      if (is_op) begin
         if (!req_q) begin
            req_d   = 1'b1;
            op_d    = op_sel;
            wdata_d = wdata_sel;
         end else if (ow.ow_done) begin
            req_d = 1'b0;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_ds18b20_sched.sv
// Directed bench for ds18b20_sched with a latency-programmable 1-Wire engine model and
// scoreboards for the engine op trace and published temperatures.
module tb_ds18b20_sched;
   import ow_pkg::*;

   localparam int unsigned CW  = 60;
   localparam int unsigned PER = 400;

   typedef logic [7:0] sp_t [9];

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        auto_en;
   logic        busy;
   logic [15:0] temp_raw;
   logic        temp_valid;
   logic        err_presence;
   logic        err_crc;

   ds18b20_sched_if owb ();

   ds18b20_sched #(
      .CONV_WAIT_CYC (CW),
      .PERIOD_CYC    (PER),
      .MAX_RETRY     (3)
   ) dut (
      .clk_in       (clk),
      .rst_n        (rst_n),
      .start        (start),
      .auto_en      (auto_en),
      .ow           (owb.master),
      .busy         (busy),
      .temp_raw     (temp_raw),
      .temp_valid   (temp_valid),
      .err_presence (err_presence),
      .err_crc      (err_crc)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   sp_t         sp, good1, good2, bad1, zero1;
   bit          pres_en = 1'b1;
   int          lat = 2;
   bit          pend = 1'b0;
   int          rd_idx = 0;
   logic [9:0]  exp_op_q[$];
   logic [15:0] exp_temp_q[$];
   int          tv_cnt = 0;
   int          rise_t[$];
   int          busy_low = 0;
   int          last_gap = 0;
   int          low_run = 0;
   int          max_low = 0;
   logic        busy_prev = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Independent bitwise CRC-8/Maxim used to build a second valid scratchpad.
   function automatic logic [7:0] crc8(input sp_t v, input int n);
      logic [7:0] c;
      logic       mix;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++) begin
            mix = c[0] ^ v[i][b];
            c   = c >> 1;
            if (mix) c = c ^ 8'h8C;
         end
      end
      return c;
   endfunction

   task automatic push_ops();
      exp_op_q.push_back(10'h000);
      exp_op_q.push_back(10'h1CC);
      exp_op_q.push_back(10'h144);
      exp_op_q.push_back(10'h000);
      exp_op_q.push_back(10'h1CC);
      exp_op_q.push_back(10'h1BE);
      for (int i = 0; i < 9; i++) exp_op_q.push_back(10'h200);
   endtask

   task automatic push_good(input logic [15:0] t);
      push_ops();
      exp_temp_q.push_back(t);
   endtask

   task automatic kick();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int n;
      n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy), 32'h0);
   endtask

   task automatic wait_rises(input string tag, input int target, input int bound);
      int n;
      n = 0;
      while (rise_t.size() < target && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(rise_t.size() >= target), 32'h1);
   endtask

   // Engine model: logs each new request against the op scoreboard, answers after lat cycles.
   initial begin : engine
      int         cnt;
      logic [9:0] got;
      owb.ow_done     = 1'b0;
      owb.ow_rdata    = 8'h00;
      owb.ow_presence = 1'b0;
      cnt = 0;
      forever begin
         @(negedge clk);
         owb.ow_done = 1'b0;
         if (!owb.ow_req) begin
            pend = 1'b0;
         end else if (!pend) begin
            pend = 1'b1;
            cnt  = lat;
            got  = {owb.ow_op, (owb.ow_op == OP_WRITE) ? owb.ow_wdata : 8'h00};
            if (owb.ow_op == OP_RESET) rd_idx = 0;
            chk("op_expected", 32'(exp_op_q.size() != 0), 32'h1);
            if (exp_op_q.size() != 0) chk("op_trace", 32'(got), 32'(exp_op_q.pop_front()));
         end else if (cnt > 0) begin
            cnt--;
         end else begin
            owb.ow_done     = 1'b1;
            owb.ow_presence = pres_en;
            if (owb.ow_op == OP_READ && rd_idx < 9) begin
               owb.ow_rdata = sp[rd_idx];
               rd_idx++;
            end
            pend = 1'b0;
         end
      end
   end

   // Output monitor: temperature scoreboard, busy start times and idle/low-request run lengths.
   initial forever begin
      @(negedge clk);
      if (temp_valid) begin
         tv_cnt++;
         chk("temp_expected", 32'(exp_temp_q.size() != 0), 32'h1);
         if (exp_temp_q.size() != 0) chk("temp_raw_on_valid", 32'(temp_raw), 32'(exp_temp_q.pop_front()));
      end
      if (busy && !busy_prev) begin
         rise_t.push_back(cyc);
         last_gap = busy_low;
      end
      if (!busy) busy_low++;
      else       busy_low = 0;
      if (busy && !owb.ow_req) begin
         low_run++;
         if (low_run > max_low) max_low = low_run;
      end else begin
         low_run = 0;
      end
      busy_prev = busy;
   end

   initial begin
      int n0, r1, r2, r3, ca, n, tv0;
      good1 = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
      bad1  = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1D};
      zero1 = '{default: 8'h00};
      good2 = '{8'h91, 8'h01, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0F, 8'h10, 8'h00};
      good2[8] = crc8(good2, 8);
      sp = good1;
      rst_n = 1'b0;
      start = 1'b0;
      auto_en = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_ow_req", 32'(owb.ow_req), 32'h0);
      chk("rst_ow_op", 32'(owb.ow_op), 32'h0);
      chk("rst_ow_wdata", 32'(owb.ow_wdata), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_temp_raw", 32'(temp_raw), 32'h0);
      chk("rst_temp_valid", 32'(temp_valid), 32'h0);
      chk("rst_err_presence", 32'(err_presence), 32'h0);
      chk("rst_err_crc", 32'(err_crc), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single good read
      push_good(16'h0550);
      max_low = 0;
      kick();
      chk("busy_next_cycle", 32'(busy), 32'h1);
      wait_idle("t1_idle", 2000);
      chk("t1_temp", 32'(temp_raw), 32'h0550);
      chk("t1_tv_cnt", 32'(tv_cnt), 32'd1);
      chk("t1_err_p", 32'(err_presence), 32'h0);
      chk("t1_err_c", 32'(err_crc), 32'h0);
      chk("t1_ops_left", 32'(exp_op_q.size()), 32'h0);
      // WAIT holds the request low CONV_WAIT_CYC cycles plus the one handshake idle cycle.
      chk("t1_conv_wait", 32'(max_low >= int'(CW) && max_low <= int'(CW) + 2), 32'h1);

      // No presence on any reset
      pres_en = 1'b0;
      repeat (3) exp_op_q.push_back(10'h000);
      kick();
      wait_idle("t2_idle", 2000);
      chk("t2_err_p", 32'(err_presence), 32'h1);
      chk("t2_err_c", 32'(err_crc), 32'h0);
      chk("t2_temp_hold", 32'(temp_raw), 32'h0550);
      chk("t2_tv_cnt", 32'(tv_cnt), 32'd1);
      chk("t2_ops_left", 32'(exp_op_q.size()), 32'h0);

      // Good read of a second pattern clears err_presence
      pres_en = 1'b1;
      sp = good2;
      push_good(16'h0191);
      kick();
      wait_idle("t3_idle", 2000);
      chk("t3_temp", 32'(temp_raw), 32'h0191);
      chk("t3_err_p", 32'(err_presence), 32'h0);
      chk("t3_tv_cnt", 32'(tv_cnt), 32'd2);

      // Corrupted CRC byte
      sp = bad1;
      repeat (3) push_ops();
      kick();
      wait_idle("t4_idle", 5000);
      chk("t4_err_c", 32'(err_crc), 32'h1);
      chk("t4_temp_hold", 32'(temp_raw), 32'h0191);
      chk("t4_tv_cnt", 32'(tv_cnt), 32'd2);
      chk("t4_ops_left", 32'(exp_op_q.size()), 32'h0);

      sp = good1;
      push_good(16'h0550);
      kick();
      wait_idle("t5_idle", 2000);
      chk("t5_err_c_clear", 32'(err_crc), 32'h0);
      chk("t5_temp", 32'(temp_raw), 32'h0550);

      // All-zero scratchpad
      sp = zero1;
      repeat (3) push_ops();
      kick();
      wait_idle("t6_idle", 5000);
      chk("t6_err_c", 32'(err_crc), 32'h1);
      chk("t6_tv_cnt", 32'(tv_cnt), 32'd3);
      chk("t6_ops_left", 32'(exp_op_q.size()), 32'h0);

      // start during the conversion wait is dropped
      sp = good1;
      push_good(16'h0550);
      kick();
      repeat (40) @(negedge clk);
      chk("t7_busy_in_wait", 32'(busy), 32'h1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("t7_idle", 2000);
      repeat (20) @(negedge clk);
      chk("t7_no_requeue", 32'(busy), 32'h0);
      chk("t7_tv_cnt", 32'(tv_cnt), 32'd4);
      chk("t7_ops_left", 32'(exp_op_q.size()), 32'h0);

      // Periodic mode, then start coinciding with expiry
      n0 = rise_t.size();
      repeat (3) push_good(16'h0550);
      @(negedge clk);
      ca = cyc;
      auto_en = 1'b1;
      wait_rises("t8_two_starts", n0 + 2, 3 * PER);
      r1 = rise_t[n0];
      r2 = rise_t[n0 + 1];
      chk("t8_immediate", 32'(r1 - ca), 32'd1);
      chk("t8_period", 32'(r2 - r1), 32'(PER));
      n = 0;
      while (cyc < r1 + 2 * int'(PER) - 1 && n < 2 * int'(PER)) begin
         @(negedge clk);
         n++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_rises("t8_third_start", n0 + 3, PER);
      auto_en = 1'b0;
      r3 = rise_t[n0 + 2];
      chk("t8_start_and_expiry", 32'(r3 - r1), 32'(2 * PER));
      wait_idle("t8_idle", 2000);
      repeat (20) @(negedge clk);
      chk("t8_single_seq", 32'(rise_t.size()), 32'(n0 + 3));
      chk("t8_ops_left", 32'(exp_op_q.size()), 32'h0);
      chk("t8_tv_cnt", 32'(tv_cnt), 32'd7);

      // Slow engine: sequence outlasts the period
      lat = 30;
      n0 = rise_t.size();
      repeat (2) push_good(16'h0550);
      @(negedge clk);
      auto_en = 1'b1;
      wait_rises("t9_two_starts", n0 + 2, 4000);
      auto_en = 1'b0;
      chk("t9_idle_gap", 32'(last_gap), 32'd1);
      chk("t9_overrun", 32'(rise_t[n0 + 1] - rise_t[n0] > int'(PER)), 32'h1);
      wait_idle("t9_idle", 2000);
      chk("t9_tv_cnt", 32'(tv_cnt), 32'd9);
      chk("t9_ops_left", 32'(exp_op_q.size()), 32'h0);
      lat = 2;

      // Reset in the middle of reading scratchpad byte 4
      push_ops();
      tv0 = tv_cnt;
      kick();
      n = 0;
      while (!(pend && rd_idx == 4 && owb.ow_op == OP_READ) && n < 1000) begin
         @(posedge clk);
         n++;
      end
      chk("t10_reached_byte4", 32'(n < 1000), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("t10_ow_req", 32'(owb.ow_req), 32'h0);
      chk("t10_busy", 32'(busy), 32'h0);
      chk("t10_temp_raw", 32'(temp_raw), 32'h0);
      chk("t10_ow_op", 32'(owb.ow_op), 32'h0);
      chk("t10_temp_valid", 32'(temp_valid), 32'h0);
      exp_op_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_good(16'h0550);
      kick();
      wait_idle("t10_idle", 2000);
      chk("t10_temp_after", 32'(temp_raw), 32'h0550);
      chk("t10_tv_cnt", 32'(tv_cnt - tv0), 32'd1);

      chk("end_ops_left", 32'(exp_op_q.size()), 32'h0);
      chk("end_temps_left", 32'(exp_temp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ds18b20_sched.md
Name: ds18b20_sched

Overview:
- Transaction-level conversion scheduler for a DS18B20 on a single 1-Wire bus.
- Sits above a byte-level 1-Wire engine (reset/presence, write byte, read byte). Sequences the reset, Skip ROM, Convert T, conversion wait, reset, Skip ROM and Read Scratchpad steps.
- CRC-checks all 9 scratchpad bytes and publishes the 16-bit raw temperature with a valid strobe.
- Supports single-shot and periodic modes, bounded retry and sticky error flags.

Parameters:
- CONV_WAIT_CYC, 768000, clk_in cycles to wait after Convert T (750 ms at 1.024 MHz).
- PERIOD_CYC, 1024000, auto-mode interval between sequence starts (1 s).
- MAX_RETRY, 3, consecutive failed attempts before giving up and flagging an error.

Ports:
- clk_in  in  1  system clock, 1.024 MHz
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle request for one measurement
- auto_en  in  1  level; enables periodic measurements
- ow_req  out  1  engine request; held high until ow_done
- ow_op  out  2  engine operation: 00 reset/presence, 01 write byte, 10 read byte
- ow_wdata  out  8  byte to write; LSB sent first by engine
- ow_done  in  1  one-cycle completion pulse from engine
- ow_rdata  in  8  byte read; valid in the ow_done cycle
- ow_presence  in  1  presence result; valid in the ow_done cycle of a reset op
- busy  out  1  high from sequence start until return to IDLE
- temp_raw  out  16  scratchpad {byte1, byte0} of the last good read
- temp_valid  out  1  one-cycle pulse when temp_raw updates
- err_presence  out  1  sticky; no presence after MAX_RETRY attempts
- err_crc  out  1  sticky; CRC or data-integrity failure after MAX_RETRY attempts

Behaviour:
- Reset values:
  - ow_req=0, ow_op=00, ow_wdata=0x00, busy=0.
  - temp_raw=0x0000, temp_valid=0, err_presence=0, err_crc=0.
  - FSM in IDLE; all counters cleared.
- Reset asserted mid-operation aborts immediately. The engine must tolerate ow_req dropping without ow_done.
- Engine handshake:
  - ow_op and ow_wdata are set in the same cycle ow_req rises and held stable while ow_req=1.
  - ow_req clears in the cycle after ow_done is sampled. The next request can rise no earlier than the cycle after that (at least 1 idle cycle).
  - ow_done while ow_req=0 is ignored.
- Sequence start:
  - In IDLE, start=1, or auto_en=1 with the period timer expired, starts a sequence.
  - busy rises the next cycle; retry count resets to 0.
  - start while busy is ignored, not queued.
  - start together with period expiry starts one sequence.
- Period timer:
  - Counts only while auto_en=1 and restarts at each sequence start. It expires at PERIOD_CYC-1.
  - If a sequence outlasts the period, the next one starts on the first IDLE cycle after it finishes.
  - When auto_en first goes high, a sequence starts immediately.
- FSM (each step issues one engine op and waits for ow_done):
  - IDLE
  - RST1: op 00. ow_presence=0 means no device → FAIL_P.
  - SKIP1: write 0xCC.
  - CONV: write 0x44.
  - WAIT: count CONV_WAIT_CYC cycles with ow_req=0.
  - RST2: op 00. No presence → FAIL_P.
  - SKIP2: write 0xCC.
  - RDCMD: write 0xBE.
  - RDBYTE: read byte, repeated 9 times. A 4-bit byte index 0..8 stores bytes 0 and 1 and folds every byte into the CRC.
  - CHECK → DONE or FAIL_C.
  - DONE: load temp_raw, pulse temp_valid, clear both error flags, return to IDLE.
- Failure handling:
  - FAIL_P / FAIL_C increment the retry count.
  - If retry < MAX_RETRY, go to RST1.
  - Otherwise set err_presence (FAIL_P) or err_crc (FAIL_C) and return to IDLE; temp_raw holds its previous value.
- CRC:
  - Dallas/Maxim CRC-8, polynomial x^8+x^5+x^4+1, reflected, init 0x00, bytes fed LSB-first.
  - After all 9 bytes the running CRC must be 0x00.
  - All-zero scratchpad (bus stuck low) also yields CRC 0x00; it is treated as FAIL_C.
- Widths:
  - Wait counter 20 bits; period counter 20 bits.
  - Both are sized to hold the parameter value; the parameters must be below 2^20.

Decomposition:
- Shared package ow_pkg:
  - op codes OP_RESET=2'b00, OP_WRITE=2'b01, OP_READ=2'b10;
  - command constants CMD_SKIP_ROM=8'hCC, CMD_CONVERT=8'h44, CMD_READ_SP=8'hBE;
  - scratchpad length SP_LEN=9;
  - FSM state enumeration.
- One sub-module, crc8_maxim: combinational byte update (crc_in, data) → crc_out. It is instantiated once; the running CRC register lives in ds18b20_sched.

Test Plan:
- start pulse; engine model returns presence and scratchpad 50 05 4B 46 7F FF 0C 10 1C → op trace 00,01(CC),01(44), then ow_req low for 768000 cycles, then 00,01(CC),01(BE),10×9; temp_raw=0x0550, one temp_valid pulse, busy drops, errors 0.
- Presence absent on every reset → exactly 3 RST1 attempts, then err_presence=1, temp_raw unchanged, busy=0; a following good read clears err_presence.
- Scratchpad with last byte 0x1D; and separately all 0x00 → 3 attempts each, err_crc=1, temp_valid never pulses.
- auto_en=1 with PERIOD_CYC=1024000 → sequence starts at 0 and at 1024000 cycles. With PERIOD_CYC reduced below sequence length → back-to-back starts with 1 IDLE cycle between.
- start asserted mid-WAIT → ignored, single temp_valid. start and period expiry in the same cycle → one sequence.
- rst_n low during RDBYTE byte 4 → ow_req and busy low asynchronously, outputs at reset values. After release, a start gives a correct read.
